// File: rtl/servo_motion_ctrl.sv
// servo_motion_ctrl
//   Motion sequencer for the servo pulse generator. Owns the commanded
//   pulse width (microseconds) and slews it toward a clamped target at most
//   SLEW_US per frame tick, so the servo never sees a step change.
//
//   Ports
//     CLK        system clock
//     RST        asynchronous active-high reset
//     step_up    one-cycle pulse: raise target by STEP_US (MANUAL only)
//     step_dn    one-cycle pulse: lower target by STEP_US (MANUAL only)
//     sweep_tog  one-cycle pulse: enter / leave sweep mode
//     recenter   one-cycle pulse: slew back to CENTER_US
//     pulse_len  commanded pulse width in us, to the servo
//     mode       0 MANUAL, 1 SWEEP_UP, 2 SWEEP_DN, 3 CENTERING
//     at_limit   registered: pulse_len sits on MIN_US or MAX_US
//     settled    registered: MANUAL and pulse_len has reached target
module servo_motion_ctrl #(
  parameter int TICK_CYCLES = 2000000,
  parameter int MIN_US      = 1000,
  parameter int MAX_US      = 2000,
  parameter int CENTER_US   = 1500,
  parameter int STEP_US     = 100,
  parameter int SLEW_US     = 10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        step_up,
  input  logic        step_dn,
  input  logic        sweep_tog,
  input  logic        recenter,
  output logic [15:0] pulse_len,
  output logic [1:0]  mode,
  output logic        at_limit,
  output logic        settled
);

  if (!(MIN_US >= 0 && MIN_US <= CENTER_US && CENTER_US <= MAX_US &&
        STEP_US >= 0 && MAX_US + STEP_US < 65536 &&
        SLEW_US > 0 && SLEW_US < 65536 && TICK_CYCLES > 0)) begin : g_bad_params
    $error("servo_motion_ctrl: illegal parameter set");
  end

  typedef enum logic [1:0] {
    MANUAL    = 2'd0,
    SWEEP_UP  = 2'd1,
    SWEEP_DN  = 2'd2,
    CENTERING = 2'd3
  } mode_e;

  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

  localparam logic [15:0] MIN_V    = 16'(MIN_US);
  localparam logic [15:0] MAX_V    = 16'(MAX_US);
  localparam logic [15:0] CENTER_V = 16'(CENTER_US);

  // 17-bit signed intermediates: every sum/difference below fits without wrap.
  localparam logic signed [16:0] MIN_S  = 17'(MIN_US);
  localparam logic signed [16:0] MAX_S  = 17'(MAX_US);
  localparam logic signed [16:0] STEP_S = 17'(STEP_US);
  localparam logic signed [16:0] SLEW_S = 17'(SLEW_US);

  localparam logic AT_LIMIT_RST = (CENTER_US == MIN_US) || (CENTER_US == MAX_US);

  function automatic logic signed [16:0] ext_us(input logic [15:0] v);
    return $signed({1'b0, v});
  endfunction

  function automatic logic [15:0] sat_us(input logic signed [16:0] v);
    if (v < MIN_S) return MIN_V;
    if (v > MAX_S) return MAX_V;
    return v[15:0];
  endfunction

  // Move p toward t by at most SLEW_US; lands exactly on t when closer.
  function automatic logic [15:0] slew_toward(input logic [15:0] p, input logic [15:0] t);
    logic signed [16:0] d;
    d = ext_us(t) - ext_us(p);
    if (d > SLEW_S)  return sat_us(ext_us(p) + SLEW_S);
    if (d < -SLEW_S) return sat_us(ext_us(p) - SLEW_S);
    return t;
  endfunction

  function automatic logic [15:0] sweep_up_us(input logic [15:0] p);
    if (MAX_S - ext_us(p) > SLEW_S) return sat_us(ext_us(p) + SLEW_S);
    return MAX_V;
  endfunction

  function automatic logic [15:0] sweep_dn_us(input logic [15:0] p);
    if (ext_us(p) - MIN_S > SLEW_S) return sat_us(ext_us(p) - SLEW_S);
    return MIN_V;
  endfunction

  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  mode_e            state_q, state_d;
  logic [15:0]      target_q, target_d;
  logic [15:0]      pulse_d;

  // ---- stage 0: free-running frame tick, independent of mode ----
  assign tick = (tick_cnt == CNT_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // ---- stage 1: command decode and slew ----
  // The slew is computed from the registered state/target, so a command
  // landing on a tick edge only affects the following ticks.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    pulse_d  = pulse_len;

    if (tick) begin
      case (state_q)
        MANUAL, CENTERING: pulse_d = slew_toward(pulse_len, target_q);
        SWEEP_UP: begin
          if (pulse_len >= MAX_V) state_d = SWEEP_DN;
          else                    pulse_d = sweep_up_us(pulse_len);
        end
        SWEEP_DN: begin
          if (pulse_len <= MIN_V) state_d = SWEEP_UP;
          else                    pulse_d = sweep_dn_us(pulse_len);
        end
        default: ;
      endcase
    end

    if (state_q == CENTERING && pulse_len == target_q) state_d = MANUAL;

    if (recenter) begin
      target_d = CENTER_V;
      state_d  = CENTERING;
    end else if (sweep_tog) begin
      case (state_q)
        MANUAL: state_d = SWEEP_UP;
        SWEEP_UP, SWEEP_DN: begin
          // Freeze where the output will actually be after this edge.
          state_d  = MANUAL;
          target_d = pulse_d;
        end
        default: ;
      endcase
    end else if (state_q == MANUAL) begin
      if (step_up && !step_dn)      target_d = sat_us(ext_us(target_q) + STEP_S);
      else if (step_dn && !step_up) target_d = sat_us(ext_us(target_q) - STEP_S);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= MANUAL;
      target_q  <= CENTER_V;
      pulse_len <= CENTER_V;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      pulse_len <= pulse_d;
    end
  end

  // ---- stage 2: status flags from the registered position ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      at_limit <= AT_LIMIT_RST;
      settled  <= 1'b1;
    end else begin
      at_limit <= (pulse_len == MIN_V) || (pulse_len == MAX_V);
      settled  <= (state_q == MANUAL) && (pulse_len == target_q);
    end
  end

  assign mode = state_q;

endmodule
